// File: rtl/an_code_pkg.sv
// Shared AN-code definitions: default code parameters, Barrett constant
// derivation and a ceil-log2 helper used to size AN-code datapaths.
package an_code_pkg;

    localparam int unsigned AN_DEF_A      = 13;
    localparam int unsigned AN_DEF_CW_W   = 12;
    localparam int unsigned AN_DEF_DATA_W = 8;
    localparam int unsigned AN_DEF_CNT_W  = 16;

    // Barrett constants for a given modulus and codeword width.
    typedef struct packed {
        logic [63:0] mu;
        logic [31:0] k;
    } an_barrett_t;

    // ceil(log2(value)); returns 0 for value <= 1.
    function automatic int unsigned clog2(input logic [63:0] value);
        int unsigned r;
        logic [63:0] v;
        r = 0;
        v = (value > 64'd0) ? value - 64'd1 : 64'd0;
        while (v > 64'd0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

    // K = 2*CW_W keeps the quotient estimate within one of the true quotient.
    function automatic an_barrett_t an_barrett_params(input int unsigned a,
                                                      input int unsigned cw_w);
        an_barrett_t p;
        p.k  = 32'(2 * cw_w);
        p.mu = (64'd1 << p.k) / 64'(a);
        return p;
    endfunction

endpackage

// File: rtl/an_barrett_core.sv
// Combinational Barrett reduce-and-correct for AN codes. The reduce half
// turns c*MU into a quotient estimate and a partial remainder; the correct
// half applies the single conditional subtraction and derives error flags.
// The halves are independent so a pipeline can register between them.
module an_barrett_core
    import an_code_pkg::*;
#(
    parameter int unsigned A      = AN_DEF_A,
    parameter int unsigned CW_W   = AN_DEF_CW_W,
    parameter int unsigned DATA_W = AN_DEF_DATA_W
) (
    // reduce
    input  logic [CW_W+clog2(an_barrett_params(A, CW_W).mu + 64'd1)-1:0] i_p,
    input  logic [CW_W-1:0]        i_c,
    output logic [CW_W-1:0]        o_q_est,
    output logic [CW_W-1:0]        o_t,
    // correct
    input  logic [CW_W-1:0]        i_q_est,
    input  logic [CW_W-1:0]        i_t,
    output logic [DATA_W-1:0]      o_q,
    output logic [clog2(A)-1:0]    o_r,
    output logic                   o_range,
    output logic                   o_err
);

    localparam an_barrett_t     BP   = an_barrett_params(A, CW_W);
    localparam int unsigned     K    = BP.k;
    localparam int unsigned     MU_W = clog2(BP.mu + 64'd1);
    localparam int unsigned     P_W  = CW_W + MU_W;
    localparam int unsigned     R_W  = clog2(A);
    localparam logic [CW_W-1:0] A_CW = CW_W'(A);

    logic            w_unused_plo;
    logic            w_corr;
    logic [CW_W-1:0] w_q;
    logic [CW_W-1:0] w_r;

    // Product bits below 2^K only carry the fractional part of c/A.
    assign w_unused_plo = ^i_p[K-1:0];

    // Quotient estimate and partial remainder; q_est*A <= c so CW_W bits are exact.
    always_comb begin
        o_q_est = CW_W'(i_p[P_W-1:K]);
        o_t     = i_c - o_q_est * A_CW;
    end

    // One correction step brings t from [0, 2A) into [0, A).
    always_comb begin
        w_corr  = (i_t >= A_CW);
        w_q     = i_q_est + CW_W'(w_corr);
        w_r     = w_corr ? (i_t - A_CW) : i_t;
        o_q     = DATA_W'(w_q);
        o_r     = R_W'(w_r);
        o_range = ((w_q >> DATA_W) != '0);
        o_err   = (w_r != '0) | o_range;
    end

endmodule

// File: rtl/an_barrett_decoder_pipe.sv
// Three-stage pipelined AN-code decoder using Barrett reduction, with a
// valid/ready stream on both sides and a saturating delivered-error counter.
module an_barrett_decoder_pipe
    import an_code_pkg::*;
#(
    parameter int unsigned A      = AN_DEF_A,
    parameter int unsigned CW_W   = AN_DEF_CW_W,
    parameter int unsigned DATA_W = AN_DEF_DATA_W,
    parameter int unsigned CNT_W  = AN_DEF_CNT_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [CW_W-1:0]     in_cw,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DATA_W-1:0]   out_q,
    output logic [clog2(A)-1:0] out_r,
    output logic                out_err,
    output logic                out_range,
    output logic [CNT_W-1:0]    err_cnt,
    input  logic                cnt_clr
);

    localparam an_barrett_t BP   = an_barrett_params(A, CW_W);
    localparam logic [63:0] MU   = BP.mu;
    localparam int unsigned MU_W = clog2(MU + 64'd1);
    localparam int unsigned P_W  = CW_W + MU_W;
    localparam int unsigned R_W  = clog2(A);

    logic              w_en;
    logic [P_W-1:0]    w_p;
    logic [CW_W-1:0]   w_q_est;
    logic [CW_W-1:0]   w_t;
    logic [DATA_W-1:0] w_q;
    logic [R_W-1:0]    w_r;
    logic              w_range;
    logic              w_err;
    logic              w_hs_err;

    logic              r_s1_valid;
    logic [CW_W-1:0]   r_s1_c;
    logic [P_W-1:0]    r_s1_p;
    logic              r_s2_valid;
    logic [CW_W-1:0]   r_s2_q_est;
    logic [CW_W-1:0]   r_s2_t;

    assign w_en     = !out_valid | out_ready;
    assign in_ready = w_en;
    assign w_p      = P_W'(in_cw) * P_W'(MU);
    assign w_hs_err = out_valid & out_ready & out_err;

    an_barrett_core #(
        .A      (A),
        .CW_W   (CW_W),
        .DATA_W (DATA_W)
    ) u_core (
        .i_p     (r_s1_p),
        .i_c     (r_s1_c),
        .o_q_est (w_q_est),
        .o_t     (w_t),
        .i_q_est (r_s2_q_est),
        .i_t     (r_s2_t),
        .o_q     (w_q),
        .o_r     (w_r),
        .o_range (w_range),
        .o_err   (w_err)
    );

    // Pipeline: all stages advance together on the global enable, so bubbles hold their slot.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_c     <= '0;
            r_s1_p     <= '0;
            r_s2_valid <= 1'b0;
            r_s2_q_est <= '0;
            r_s2_t     <= '0;
            out_valid  <= 1'b0;
            out_q      <= '0;
            out_r      <= '0;
            out_err    <= 1'b0;
            out_range  <= 1'b0;
        end else if (w_en) begin
            r_s1_valid <= in_valid;
            r_s1_c     <= in_cw;
            r_s1_p     <= w_p;
            r_s2_valid <= r_s1_valid;
            r_s2_q_est <= w_q_est;
            r_s2_t     <= w_t;
            out_valid  <= r_s2_valid;
            out_q      <= w_q;
            out_r      <= w_r;
            out_err    <= w_err;
            out_range  <= w_range;
        end
    end

    // Saturating count of delivered erroring results; a clear still counts a coincident one.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt <= '0;
        end else if (cnt_clr) begin
            err_cnt <= w_hs_err ? CNT_W'(1) : '0;
        end else if (w_hs_err && (err_cnt != '1)) begin
            err_cnt <= err_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_an_barrett_decoder_pipe.sv
// Self-checking bench for an_barrett_decoder_pipe: randomized streams and
// directed scenarios checked against arithmetic division/modulo results.
module tb_an_barrett_decoder_pipe;

    localparam int unsigned A      = 13;
    localparam int unsigned CW_W   = 12;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned CNT_W  = 16;
    localparam int unsigned R_W    = 4;

    logic              clk;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [CW_W-1:0]   in_cw;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_q;
    logic [R_W-1:0]    out_r;
    logic              out_err;
    logic              out_range;
    logic [CNT_W-1:0]  err_cnt;
    logic              cnt_clr;

    int n_checks = 0;
    int n_fails  = 0;

    int stim[$];
    int in_cyc[$];
    int obs_q[$];
    int obs_r[$];
    int obs_err[$];
    int obs_rng[$];
    int obs_cyc[$];

    an_barrett_decoder_pipe #(
        .A      (A),
        .CW_W   (CW_W),
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_cw     (in_cw),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_q     (out_q),
        .out_r     (out_r),
        .out_err   (out_err),
        .out_range (out_range),
        .err_cnt   (err_cnt),
        .cnt_clr   (cnt_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: plain integer division and modulo.
    function automatic int m_q(input int c);
        return (c / A) % (1 << DATA_W);
    endfunction
    function automatic int m_r(input int c);
        return c % A;
    endfunction
    function automatic int m_rng(input int c);
        return ((c / A) > ((1 << DATA_W) - 1)) ? 1 : 0;
    endfunction
    function automatic int m_err(input int c);
        return ((m_r(c) != 0) || (m_rng(c) != 0)) ? 1 : 0;
    endfunction
    function automatic int m_err_count(input int n);
        int cnt;
        cnt = 0;
        for (int i = 0; i < n; i++) cnt += m_err(stim[i]);
        return (cnt > 65535) ? 65535 : cnt;
    endfunction

    // The partial remainder must always lie below 2A.
    always @(negedge clk) begin
        if (!rst && dut.r_s2_valid) begin
            n_checks++;
            if (32'(dut.r_s2_t) >= 2 * A) begin
                n_fails++;
                $display("FAIL t_bound: t=%0d required < %0d", dut.r_s2_t, 2 * A);
            end
        end
    end

    initial begin
        #800us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic drive_cycle(input logic r, input logic v, input int cw,
                               input logic rdy, input logic clr);
        @(negedge clk);
        rst       = r;
        in_valid  = v;
        in_cw     = CW_W'(cw);
        out_ready = rdy;
        cnt_clr   = clr;
        #1;
    endtask

    task automatic do_reset();
        drive_cycle(1'b1, 1'b0, 0, 1'b1, 1'b0);
        drive_cycle(1'b1, 1'b0, 0, 1'b1, 1'b0);
        drive_cycle(1'b0, 1'b0, 0, 1'b1, 1'b0);
    endtask

    // Streams stim[] through the DUT and records every delivered result.
    task automatic run_stream(input int rdy_pct, input int max_cyc);
        int   idx;
        int   cyc;
        logic v;
        logic rdy;
        idx = 0;
        cyc = 0;
        in_cyc.delete(); obs_q.delete(); obs_r.delete();
        obs_err.delete(); obs_rng.delete(); obs_cyc.delete();
        while (((idx < stim.size()) || (obs_q.size() < stim.size())) && (cyc < max_cyc)) begin
            v   = (idx < stim.size());
            rdy = ($urandom_range(99) < rdy_pct);
            drive_cycle(1'b0, v, v ? stim[idx] : 0, rdy, 1'b0);
            if (out_valid && out_ready) begin
                obs_q.push_back(int'(out_q));
                obs_r.push_back(int'(out_r));
                obs_err.push_back(int'(out_err));
                obs_rng.push_back(int'(out_range));
                obs_cyc.push_back(cyc);
            end
            if (v && in_ready) begin
                in_cyc.push_back(cyc);
                idx++;
            end
            cyc++;
        end
        drive_cycle(1'b0, 1'b0, 0, 1'b1, 1'b0);
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if (out_valid !== 1'b0 || out_q !== '0 || out_r !== '0 || out_err !== 1'b0 ||
            out_range !== 1'b0 || err_cnt !== '0) begin
            n_fails++;
            $display("FAIL reset_state: valid=%b q=%0d r=%0d err=%b rng=%b cnt=%0d required all 0",
                     out_valid, out_q, out_r, out_err, out_range, err_cnt);
        end
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fails++;
            $display("FAIL reset_in_ready: got %b required 1", in_ready);
        end
    endtask

    task automatic test_basic();
        do_reset();
        stim = '{65};
        run_stream(100, 50);
        n_checks++;
        if (obs_q.size() != 1) begin
            n_fails++;
            $display("FAIL basic_count: got %0d results required 1", obs_q.size());
        end else begin
            n_checks++;
            if (obs_q[0] !== m_q(65) || obs_r[0] !== m_r(65) || obs_err[0] !== m_err(65) ||
                obs_rng[0] !== m_rng(65)) begin
                n_fails++;
                $display("FAIL basic_65: got q=%0d r=%0d err=%0d rng=%0d required q=%0d r=%0d err=%0d rng=%0d",
                         obs_q[0], obs_r[0], obs_err[0], obs_rng[0], m_q(65), m_r(65), m_err(65), m_rng(65));
            end
            n_checks++;
            if (obs_cyc[0] - in_cyc[0] != 3) begin
                n_fails++;
                $display("FAIL basic_latency: got %0d cycles required 3", obs_cyc[0] - in_cyc[0]);
            end
        end
        n_checks++;
        if (err_cnt !== CNT_W'(m_err_count(stim.size()))) begin
            n_fails++;
            $display("FAIL basic_err_cnt: got %0d required %0d", err_cnt, m_err_count(stim.size()));
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        stim = '{66, 77};
        run_stream(100, 50);
        n_checks++;
        if (obs_q.size() != 2) begin
            n_fails++;
            $display("FAIL b2b_count: got %0d results required 2", obs_q.size());
        end else begin
            for (int i = 0; i < 2; i++) begin
                n_checks++;
                if (obs_q[i] !== m_q(stim[i]) || obs_r[i] !== m_r(stim[i]) ||
                    obs_err[i] !== m_err(stim[i]) || obs_rng[i] !== m_rng(stim[i])) begin
                    n_fails++;
                    $display("FAIL b2b_item c=%0d: got q=%0d r=%0d err=%0d rng=%0d required q=%0d r=%0d err=%0d rng=%0d",
                             stim[i], obs_q[i], obs_r[i], obs_err[i], obs_rng[i],
                             m_q(stim[i]), m_r(stim[i]), m_err(stim[i]), m_rng(stim[i]));
                end
            end
            n_checks++;
            if (obs_cyc[1] != obs_cyc[0] + 1 || in_cyc[1] != in_cyc[0] + 1) begin
                n_fails++;
                $display("FAIL b2b_throughput: out gap %0d in gap %0d required 1 and 1",
                         obs_cyc[1] - obs_cyc[0], in_cyc[1] - in_cyc[0]);
            end
        end
        n_checks++;
        if (err_cnt !== CNT_W'(m_err_count(stim.size()))) begin
            n_fails++;
            $display("FAIL b2b_err_cnt: got %0d required %0d", err_cnt, m_err_count(stim.size()));
        end
    endtask

    task automatic test_boundary();
        do_reset();
        stim = '{3315, 4095, 0, 4094, 13, 3327, 3328};
        run_stream(100, 60);
        n_checks++;
        if (obs_q.size() != stim.size()) begin
            n_fails++;
            $display("FAIL bound_count: got %0d results required %0d", obs_q.size(), stim.size());
        end else begin
            for (int i = 0; i < stim.size(); i++) begin
                n_checks++;
                if (obs_q[i] !== m_q(stim[i]) || obs_r[i] !== m_r(stim[i]) ||
                    obs_err[i] !== m_err(stim[i]) || obs_rng[i] !== m_rng(stim[i])) begin
                    n_fails++;
                    $display("FAIL bound_item c=%0d: got q=%0d r=%0d err=%0d rng=%0d required q=%0d r=%0d err=%0d rng=%0d",
                             stim[i], obs_q[i], obs_r[i], obs_err[i], obs_rng[i],
                             m_q(stim[i]), m_r(stim[i]), m_err(stim[i]), m_rng(stim[i]));
                end
            end
        end
        n_checks++;
        if (err_cnt !== CNT_W'(m_err_count(stim.size()))) begin
            n_fails++;
            $display("FAIL bound_err_cnt: got %0d required %0d", err_cnt, m_err_count(stim.size()));
        end
    endtask

    task automatic test_stream();
        do_reset();
        stim.delete();
        for (int c = 0; c < (1 << CW_W); c++) stim.push_back(c);
        run_stream(60, 40000);
        n_checks++;
        if (obs_q.size() != stim.size()) begin
            n_fails++;
            $display("FAIL stream_count: got %0d results required %0d", obs_q.size(), stim.size());
        end
        for (int i = 0; i < obs_q.size() && i < stim.size(); i++) begin
            n_checks++;
            if (obs_q[i] !== m_q(stim[i]) || obs_r[i] !== m_r(stim[i]) ||
                obs_err[i] !== m_err(stim[i]) || obs_rng[i] !== m_rng(stim[i])) begin
                n_fails++;
                $display("FAIL stream_item c=%0d: got q=%0d r=%0d err=%0d rng=%0d required q=%0d r=%0d err=%0d rng=%0d",
                         stim[i], obs_q[i], obs_r[i], obs_err[i], obs_rng[i],
                         m_q(stim[i]), m_r(stim[i]), m_err(stim[i]), m_rng(stim[i]));
            end
        end
        n_checks++;
        if (err_cnt !== CNT_W'(m_err_count(stim.size()))) begin
            n_fails++;
            $display("FAIL stream_err_cnt: got %0d required %0d", err_cnt, m_err_count(stim.size()));
        end
    endtask

    task automatic test_stall();
        int items[3];
        int d;
        int seen[$];
        int seen_k[$];
        do_reset();
        for (int i = 0; i < 3; i++) items[i] = int'($urandom_range((1 << CW_W) - 1));
        d = int'($urandom_range((1 << CW_W) - 1));
        for (int i = 0; i < 3; i++) drive_cycle(1'b0, 1'b1, items[i], 1'b0, 1'b0);
        for (int k = 0; k < 6; k++) begin
            drive_cycle(1'b0, 1'b1, d, 1'b0, 1'b0);
            n_checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_q !== DATA_W'(m_q(items[0])) ||
                out_r !== R_W'(m_r(items[0]))) begin
                n_fails++;
                $display("FAIL stall_hold k=%0d: in_ready=%b valid=%b q=%0d r=%0d required 0 1 q=%0d r=%0d",
                         k, in_ready, out_valid, out_q, out_r, m_q(items[0]), m_r(items[0]));
            end
        end
        for (int k = 0; k < 6; k++) begin
            drive_cycle(1'b0, 1'b0, 0, 1'b1, 1'b0);
            if (out_valid) begin
                seen.push_back(int'(out_q) * 16 + int'(out_r));
                seen_k.push_back(k);
            end
        end
        n_checks++;
        if (seen.size() != 3) begin
            n_fails++;
            $display("FAIL stall_release_count: got %0d results required 3", seen.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                n_checks++;
                if (seen[i] != m_q(items[i]) * 16 + m_r(items[i]) || seen_k[i] != i) begin
                    n_fails++;
                    $display("FAIL stall_release_item %0d: got q*16+r=%0d at cycle %0d required %0d at cycle %0d",
                             i, seen[i], seen_k[i], m_q(items[i]) * 16 + m_r(items[i]), i);
                end
            end
        end
    endtask

    task automatic test_reset_midstream();
        int seen;
        do_reset();
        drive_cycle(1'b0, 1'b1, 66, 1'b1, 1'b0);
        for (int k = 0; k < 4; k++) drive_cycle(1'b0, 1'b0, 0, 1'b1, 1'b0);
        n_checks++;
        if (err_cnt !== CNT_W'(1)) begin
            n_fails++;
            $display("FAIL midrst_pre_cnt: got %0d required 1", err_cnt);
        end
        drive_cycle(1'b0, 1'b1, 77, 1'b1, 1'b0);
        drive_cycle(1'b0, 1'b1, 78, 1'b1, 1'b0);
        drive_cycle(1'b1, 1'b0, 0, 1'b1, 1'b0);
        drive_cycle(1'b0, 1'b0, 0, 1'b1, 1'b0);
        n_checks++;
        if (out_valid !== 1'b0 || err_cnt !== '0 || in_ready !== 1'b1) begin
            n_fails++;
            $display("FAIL midrst_state: valid=%b cnt=%0d in_ready=%b required 0 0 1",
                     out_valid, err_cnt, in_ready);
        end
        seen = 0;
        for (int k = 0; k < 6; k++) begin
            drive_cycle(1'b0, 1'b0, 0, 1'b1, 1'b0);
            if (out_valid) seen++;
        end
        n_checks++;
        if (seen != 0) begin
            n_fails++;
            $display("FAIL midrst_ghost: got %0d discarded results delivered required 0", seen);
        end
    endtask

    task automatic test_cnt_clr();
        do_reset();
        drive_cycle(1'b0, 1'b1, 77, 1'b1, 1'b0);
        drive_cycle(1'b0, 1'b1, 66, 1'b1, 1'b0);
        drive_cycle(1'b0, 1'b0, 0, 1'b1, 1'b0);
        drive_cycle(1'b0, 1'b0, 0, 1'b1, 1'b0);
        drive_cycle(1'b0, 1'b0, 0, 1'b1, 1'b1);
        n_checks++;
        if (out_valid !== 1'b1 || out_r !== R_W'(m_r(66)) || err_cnt !== CNT_W'(1)) begin
            n_fails++;
            $display("FAIL clr_setup: valid=%b r=%0d cnt=%0d required 1 %0d 1",
                     out_valid, out_r, err_cnt, m_r(66));
        end
        drive_cycle(1'b0, 1'b0, 0, 1'b1, 1'b1);
        n_checks++;
        if (err_cnt !== CNT_W'(1)) begin
            n_fails++;
            $display("FAIL clr_with_err: got %0d required 1", err_cnt);
        end
        drive_cycle(1'b0, 1'b0, 0, 1'b1, 1'b0);
        n_checks++;
        if (err_cnt !== '0) begin
            n_fails++;
            $display("FAIL clr_plain: got %0d required 0", err_cnt);
        end
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_cw     = '0;
        out_ready = 1'b1;
        cnt_clr   = 1'b0;
        test_reset();
        test_basic();
        test_back_to_back();
        test_boundary();
        test_stream();
        test_stall();
        test_reset_midstream();
        test_cnt_clr();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/an_barrett_decoder_pipe.md
Name: an_barrett_decoder_pipe

Overview:
Parametrised, pipelined AN-code decoder using Barrett reduction. Accepts codewords c = A*d (+ possible error) on a valid/ready stream. Returns quotient d, remainder r, error and range flags, and keeps a saturating error counter. It is the streaming, any-modulus successor of the team's fixed-width combinational Barrett decoders and sits between the AN-coded storage/ALU datapath and the consumer.

Parameters:
A, 13, odd modulus of the AN code (A >= 3).
CW_W, 12, codeword width in bits; requires 2^CW_W > A.
DATA_W, 8, decoded data (quotient) width.
CNT_W, 16, error-counter width.
(derived localparams) K = 2*CW_W; MU = floor(2^K / A); R_W = clog2(A).

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous, active-high reset
in_valid  in  1  codeword valid
in_ready  out  1  block can accept a codeword this cycle
in_cw  in  CW_W  received codeword
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
out_q  out  DATA_W  quotient floor(c/A) mod 2^DATA_W
out_r  out  R_W  remainder c mod A
out_err  out  1  out_r != 0 OR out_range
out_range  out  1  true quotient > 2^DATA_W-1
err_cnt  out  CNT_W  saturating count of delivered results with out_err=1
cnt_clr  in  1  clears err_cnt

Behaviour:
- Reset (rst=1 at a clock edge): all stage valids, out_valid, out_q, out_r, out_err, out_range and err_cnt go to 0. In-flight data is discarded. in_ready reads 1 in the cycle after reset.
- Pipeline has 3 register stages, a global enable en = !out_valid | out_ready, and in_ready = en. Latency is 3 cycles from input handshake to out_valid when there is no stall. Throughput is 1 per cycle.
  - S1: p = in_cw * MU, full width CW_W + bits(MU).
  - S2: q_est = p >> K; t = c - q_est*A. Both are computed at full width, and c is piped alongside.
  - S3: if t >= A, then q = q_est+1 and r = t-A; else q = q_est and r = t. out_range = (q >> DATA_W) != 0.
- Correctness bound: with K = 2*CW_W, q_est is either floor(c/A) or floor(c/A)-1. At most one correction step is needed. The bench asserts t < 2A.
- Stall: when out_valid=1 and out_ready=0, every stage holds and in_ready=0. Data is never lost or duplicated. A bubble does not collapse while stalled.
- Stage valid bits advance with en. A bubble (valid=0) in a stage produces no output and no counter update.
- err_cnt increments by 1 on each output handshake (out_valid & out_ready) with out_err=1. It saturates at 2^CW... more precisely at 2^CNT_W-1.
- cnt_clr=1 sets err_cnt to 0. If an erroring handshake occurs in the same cycle, err_cnt becomes 1.
- Widths: all intermediate arithmetic is unsigned. The quotient is kept at CW_W bits internally and truncated to DATA_W only on out_q.
- Boundary cases:
  - c=0 gives q=0, r=0, err=0.
  - c = 2^CW_W-1 must decode exactly.
  - A = 2^k+1 style moduli need no special case.

Decomposition:
- Shared package an_code_pkg holds:
  - the function computing MU and K for a given A and CW_W;
  - the clog2 helper;
  - the default A/CW_W/DATA_W constants used across AN-code blocks.
- One natural sub-module, an_barrett_core: the purely combinational S2/S3 reduce-and-correct logic, reused by the existing combinational decoders.
- The pipeline, handshake and counter stay in the top module.

Test Plan:
- Defaults (A=13, CW_W=12, DATA_W=8), out_ready=1. Send in_cw=65 -> after 3 cycles out_q=5, out_r=0, out_err=0, out_range=0, err_cnt=0.
- Send in_cw=66, then 77, back-to-back. Expect 66 -> q=5, r=1, err=1; 77 -> q=5, r=12, err=1; err_cnt=2; one result per cycle.
- Send in_cw=3315 -> q=255, r=0, err=0. Send in_cw=4095 -> q=59 (315 mod 256), r=0, out_range=1, err=1.
- Stream 0..4095 with random out_ready. For every c, check q = (c/13) mod 256 and r = c%13. Check order is preserved, no drops/duplicates, and the t<2A assertion never fires.
- Hold out_ready=0 with 3 items in flight: in_ready=0 and outputs stay stable. Release: the items emerge in order, one per cycle.
- Reset mid-stream with 2 items in flight -> next cycle out_valid=0 and err_cnt=0; the discarded items never appear. Then assert cnt_clr together with an erroring handshake -> err_cnt=1.
